// File: rtl/i2c_codec_pkg.sv
// Shared definitions for the I2C codec register responder.
// Holds the controller state encoding, the address whose write restores all
// registers to their power-on values, and the power-on value table.
package i2c_codec_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAckA,
    StByte1,
    StAck1,
    StByte2,
    StAck2,
    StWaitStop
  } state_e;

  // A write to this register address reloads every register with its default.
  localparam logic [6:0] RstRegAddr = 7'h0F;

  // Power-on value of register idx; registers beyond R7 default to zero.
  function automatic logic [8:0] reg_default(input int unsigned idx);
    logic [8:0] v;
    case (idx)
      0, 1:    v = 9'h097;
      2, 3:    v = 9'h079;
      4:       v = 9'h00A;
      5:       v = 9'h008;
      6:       v = 9'h09F;
      7:       v = 9'h00A;
      default: v = 9'h000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/i2c_codec_responder_if.sv
// I2C pad-side bundle for the codec responder.
//   i2c_sclk    : clock from the bus initiator (asynchronous to clk)
//   i2c_sdat_in : SDA as read back from the pad (asynchronous to clk)
//   i2c_sdat_oe : 1 = responder pulls SDA low, 0 = released (open-drain)
// master modport: the bus initiator side; slave modport: the responder.
interface i2c_codec_responder_if;
  logic i2c_sclk;
  logic i2c_sdat_in;
  logic i2c_sdat_oe;

  modport master (
    output i2c_sclk,
    output i2c_sdat_in,
    input  i2c_sdat_oe
  );

  modport slave (
    input  i2c_sclk,
    input  i2c_sdat_in,
    output i2c_sdat_oe
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus one history flop for a single I2C line.
//   clk, reset_n : system clock, synchronous active-low reset
//   i_line       : asynchronous line input
//   o_level      : synchronized level
//   o_rise/o_fall: one-cycle pulses on synchronized edges
// Reset loads ones so an idle (pulled-up) bus produces no spurious edges.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], i_line};
    end
  end

  assign o_level = r_sync[1];
  assign o_rise  = r_sync[1] & ~r_sync[2];
  assign o_fall  = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target holding NREGS 9-bit codec registers.
//   clk, reset_n : system clock, synchronous active-low reset
//   bus          : I2C pad bundle (slave modport)
//   rd_addr/rd_data : combinational register readback (0 when out of range)
//   wr_strobe/wr_addr/wr_data : one-cycle pulse and held copy of last commit
//   busy         : transaction in progress (START seen, no STOP/IDLE yet)
//   nack_count   : saturating count of read requests that were refused
// Each 16-bit word is {reg_addr[6:0], data[8]} then data[7:0]; the word commits
// when the ACK after its second byte is released.
module i2c_codec_responder
  import i2c_codec_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned NREGS    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  i2c_codec_responder_if.slave  bus,
  input  logic [6:0]            rd_addr,
  output logic [8:0]            rd_data,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [8:0]            wr_data,
  output logic                  busy,
  output logic [7:0]            nack_count
);

  logic w_scl_level, w_scl_rise, w_scl_fall;
  logic w_sda_level, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_sync_edge u_sync_scl (
    .clk     (clk),
    .reset_n (reset_n),
    .i_line  (bus.i2c_sclk),
    .o_level (w_scl_level),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge u_sync_sda (
    .clk     (clk),
    .reset_n (reset_n),
    .i_line  (bus.i2c_sdat_in),
    .o_level (w_sda_level),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_level;
  assign w_stop  = w_sda_rise & w_scl_level;

  state_e     r_state, w_state_d;
  logic [3:0] r_bit_cnt, w_bit_cnt_d;
  logic [7:0] r_shift, w_shift_d;
  logic [6:0] r_word_addr, w_word_addr_d;
  logic       r_word_msb, w_word_msb_d;
  logic [7:0] r_word_lo, w_word_lo_d;
  logic       w_commit;
  logic       w_nack;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_word_addr <= '0;
      r_word_msb  <= 1'b0;
      r_word_lo   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_shift     <= w_shift_d;
      r_word_addr <= w_word_addr_d;
      r_word_msb  <= w_word_msb_d;
      r_word_lo   <= w_word_lo_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_bit_cnt_d   = r_bit_cnt;
    w_shift_d     = r_shift;
    w_word_addr_d = r_word_addr;
    w_word_msb_d  = r_word_msb;
    w_word_lo_d   = r_word_lo;
    w_commit      = 1'b0;
    w_nack        = 1'b0;
    if (w_stop) begin
      w_state_d = StIdle;
    end else if (w_start) begin
      // Repeated START also lands here and drops any partial word.
      w_state_d   = StAddr;
      w_bit_cnt_d = '0;
    end else begin
      unique case (r_state)
        StAddr, StByte1, StByte2: begin
          if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
            w_shift_d   = {r_shift[6:0], w_sda_level};
            w_bit_cnt_d = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
            // Falling edge ending bit 8: decide and drive the ACK slot.
            w_bit_cnt_d = '0;
            if (r_state == StAddr) begin
              if (r_shift == {DEV_ADDR, 1'b0}) begin
                w_state_d = StAckA;
              end else begin
                w_nack    = (r_shift == {DEV_ADDR, 1'b1});
                w_state_d = StWaitStop;
              end
            end else if (r_state == StByte1) begin
              w_word_addr_d = r_shift[7:1];
              w_word_msb_d  = r_shift[0];
              w_state_d     = StAck1;
            end else begin
              w_word_lo_d = r_shift;
              w_state_d   = StAck2;
            end
          end
        end
        StAckA: if (w_scl_fall) w_state_d = StByte1;
        StAck1: if (w_scl_fall) w_state_d = StByte2;
        StAck2: begin
          if (w_scl_fall) begin
            w_state_d = StByte1;
            w_commit  = 1'b1;
          end
        end
        default: ;  // StIdle and StWaitStop only leave on START/STOP
      endcase
    end
  end

  assign bus.i2c_sdat_oe = (r_state == StAckA) || (r_state == StAck1) || (r_state == StAck2);
  assign busy            = (r_state != StIdle);

  logic [8:0] r_regs [NREGS];
  logic       r_wr_strobe;
  logic [6:0] r_wr_addr;
  logic [8:0] r_wr_data;
  logic [7:0] r_nack_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_strobe  <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_nack_count <= '0;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= reg_default(i);
    end else begin
      r_wr_strobe <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_word_addr;
        r_wr_data <= {r_word_msb, r_word_lo};
      end
      if (w_nack && (r_nack_count != 8'hFF)) r_nack_count <= r_nack_count + 8'd1;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (w_commit) begin
          if (r_word_addr == RstRegAddr) begin
            r_regs[i] <= reg_default(i);
          end else if (r_word_addr == 7'(i)) begin
            r_regs[i] <= {r_word_msb, r_word_lo};
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rd_addr == 7'(i)) rd_data = r_regs[i];
    end
  end

  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign nack_count = r_nack_count;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Self-checking bench for i2c_codec_responder: bit-banged I2C initiator,
// table of transactions, hand sequences for multi-cycle corners, and random
// transactions checked against a register-map model.
module tb_i2c_codec_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m_scl, m_sda;
  logic [6:0] rd_addr;
  logic [8:0] rd_data;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic [7:0] nack_count;

  always #5 clk = ~clk;

  i2c_codec_responder_if bus_if ();
  assign bus_if.i2c_sclk    = m_scl;
  // Open-drain wire: line is low if either side pulls it low.
  assign bus_if.i2c_sdat_in = m_sda & ~bus_if.i2c_sdat_oe;

  i2c_codec_responder #(.DEV_ADDR(7'h1A), .NREGS(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .nack_count (nack_count)
  );

  int n_vec = 0;
  int n_err = 0;
  int q     = 10;  // quarter SCL period in clk cycles
  int strobe_cnt = 0;
  int oe_cnt     = 0;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt++;
    if (bus_if.i2c_sdat_oe === 1'b1) oe_cnt++;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [8:0] dflt [16] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
                            9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
  logic [8:0] m_regs [16];
  int         m_strobes = 0;
  logic [6:0] m_wr_addr;
  logic [8:0] m_wr_data;
  int         m_nack;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = dflt[i];
    m_wr_addr = '0;
    m_wr_data = '0;
    m_nack    = 0;
  endtask

  // Complete transaction: address byte a, then (if write to us) one word.
  task automatic model_xfer(input logic [7:0] a, input logic [6:0] ra, input logic [8:0] d);
    if (a == 8'h34) begin
      m_strobes++;
      m_wr_addr = ra;
      m_wr_data = d;
      if (ra == 7'h0F) for (int i = 0; i < 16; i++) m_regs[i] = dflt[i];
      else if (ra < 7'd16) m_regs[ra[3:0]] = d;
    end else if (a == 8'h35 && m_nack < 255) begin
      m_nack++;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 7'(i);
      #1;
      check($sformatf("%s rd[%0d]", tag, i), 32'(rd_data), 32'(m_regs[i]));
    end
    rd_addr = 7'h10;
    #1;
    check($sformatf("%s rd[10]", tag), 32'(rd_data), 32'h0);
    rd_addr = 7'h7F;
    #1;
    check($sformatf("%s rd[7f]", tag), 32'(rd_data), 32'h0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " strobes"}, 32'(strobe_cnt), 32'(m_strobes));
    check({tag, " wr_addr"}, 32'(wr_addr), 32'(m_wr_addr));
    check({tag, " wr_data"}, 32'(wr_data), 32'(m_wr_data));
    check({tag, " nack"}, 32'(nack_count), 32'(m_nack));
    check({tag, " busy"}, 32'(busy), 32'h0);
  endtask

  // ---------------- I2C initiator ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_clk(q);
    m_sda = 1'b0;
    wait_clk(q);
    m_scl = 1'b0;
    wait_clk(q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_clk(q);
    m_scl = 1'b1;
    wait_clk(q);
    m_sda = 1'b1;
    wait_clk(q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    wait_clk(q);
    m_scl = 1'b1;
    wait_clk(2 * q);
    m_scl = 1'b0;
    wait_clk(q);
  endtask

  task automatic send_byte(input logic [7:0] b, output int ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1;
    wait_clk(q);
    m_scl = 1'b1;
    wait_clk(q);
    ack = (bus_if.i2c_sdat_in === 1'b0) ? 1 : 0;
    wait_clk(q);
    m_scl = 1'b0;
    wait_clk(q);
  endtask

  task automatic xfer(input logic [7:0] a, input logic [6:0] ra, input logic [8:0] d,
                      output int acks);
    int ack;
    acks = 0;
    i2c_start();
    send_byte(a, ack);
    acks += ack;
    if (ack != 0) begin
      send_byte({ra, d[8]}, ack);
      acks += ack;
      send_byte(d[7:0], ack);
      acks += ack;
    end
    i2c_stop();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] addr_byte;
    logic [6:0] reg_addr;
    logic [8:0] data;
    int         exp_acks;
    int         exp_strobes;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int acks, ack, oe0, s0;
    vecs[0] = '{8'h34, 7'h02, 9'h1A5, 3, 1};
    vecs[1] = '{8'h35, 7'h05, 9'h0AA, 0, 0};  // read request: refused
    vecs[2] = '{8'h30, 7'h05, 9'h0AA, 0, 0};  // other device
    vecs[3] = '{8'h34, 7'h20, 9'h0FF, 3, 1};  // out-of-range register
    vecs[4] = '{8'h36, 7'h01, 9'h011, 0, 0};  // other device
    vecs[5] = '{8'h34, 7'h0E, 9'h100, 3, 1};

    reset_n = 1'b0;
    m_scl   = 1'b1;
    m_sda   = 1'b1;
    rd_addr = '0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(2);
    model_reset();
    check("reset oe", 32'(bus_if.i2c_sdat_oe), 32'h0);
    check("reset wr_strobe", 32'(wr_strobe), 32'h0);
    check_outputs("reset");
    check_regs("reset");

    // Single word at SCL = clk/500.
    q = 125;
    xfer(8'h34, 7'h04, 9'h012, acks);
    model_xfer(8'h34, 7'h04, 9'h012);
    check("slow acks", 32'(acks), 32'd3);
    check_outputs("slow");
    rd_addr = 7'h04;
    #1;
    check("slow rd4", 32'(rd_data), 32'h012);
    q = 10;

    foreach (vecs[i]) begin
      oe0 = oe_cnt;
      s0  = strobe_cnt;
      xfer(vecs[i].addr_byte, vecs[i].reg_addr, vecs[i].data, acks);
      model_xfer(vecs[i].addr_byte, vecs[i].reg_addr, vecs[i].data);
      check($sformatf("vec%0d acks", i), 32'(acks), 32'(vecs[i].exp_acks));
      check($sformatf("vec%0d strobe delta", i), 32'(strobe_cnt - s0), 32'(vecs[i].exp_strobes));
      if (vecs[i].exp_acks == 0)
        check($sformatf("vec%0d oe cycles", i), 32'(oe_cnt - oe0), 32'h0);
      check_outputs($sformatf("vec%0d", i));
      check_regs($sformatf("vec%0d", i));
    end

    // Register-reset address restores defaults.
    xfer(8'h34, 7'h04, 9'h1FF, acks);
    model_xfer(8'h34, 7'h04, 9'h1FF);
    rd_addr = 7'h04;
    #1;
    check("r4 written", 32'(rd_data), 32'h1FF);
    xfer(8'h34, 7'h0F, 9'h000, acks);
    model_xfer(8'h34, 7'h0F, 9'h000);
    rd_addr = 7'h04;
    #1;
    check("r4 default", 32'(rd_data), 32'h00A);
    rd_addr = 7'h06;
    #1;
    check("r6 default", 32'(rd_data), 32'h09F);
    check_outputs("regrst");

    // Two words, then STOP after byte 1 of a third word.
    s0   = strobe_cnt;
    acks = 0;
    i2c_start();
    send_byte(8'h34, ack);       acks += ack;
    send_byte({7'h00, 1'b1}, ack); acks += ack;
    send_byte(8'h00, ack);       acks += ack;
    send_byte({7'h01, 1'b0}, ack); acks += ack;
    send_byte(8'h55, ack);       acks += ack;
    send_byte({7'h02, 1'b1}, ack); acks += ack;
    i2c_stop();
    model_xfer(8'h34, 7'h00, 9'h100);
    model_xfer(8'h34, 7'h01, 9'h055);
    check("multi acks", 32'(acks), 32'd6);
    check("multi strobe delta", 32'(strobe_cnt - s0), 32'd2);
    check_outputs("multi");
    check_regs("multi");

    // Reset during the second data byte.
    i2c_start();
    send_byte(8'h34, ack);
    send_byte({7'h03, 1'b0}, ack);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("midreset busy before", 32'(busy), 32'h1);
    reset_n = 1'b0;
    wait_clk(1);
    reset_n = 1'b1;
    check("midreset oe", 32'(bus_if.i2c_sdat_oe), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    m_sda = 1'b1;
    wait_clk(q);
    m_scl = 1'b1;
    wait_clk(q);
    model_reset();
    check_outputs("midreset");
    check_regs("midreset");
    xfer(8'h34, 7'h03, 9'h133, acks);
    model_xfer(8'h34, 7'h03, 9'h133);
    check("after reset acks", 32'(acks), 32'd3);
    check_outputs("after reset");
    check_regs("after reset");

    // Random transactions against the model.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] a;
      logic [6:0] ra;
      logic [8:0] d;
      int         sel;
      sel = int'($urandom_range(0, 9));
      a   = (sel < 7) ? 8'h34 : (sel == 7) ? 8'h35 : 8'($urandom_range(0, 255));
      ra  = 7'($urandom_range(0, 20));
      d   = 9'($urandom_range(0, 511));
      xfer(a, ra, d, acks);
      model_xfer(a, ra, d);
      check($sformatf("rand%0d acks", k), 32'(acks), (a == 8'h34) ? 32'd3 : 32'd0);
      check_outputs($sformatf("rand%0d", k));
      check_regs($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 SHALL provide parameter DEV_ADDR, default 7'h1A, 7-bit I2C target address to which the block responds.
REQ-002 SHALL provide parameter NREGS, default 16, number of 9-bit registers held; register addresses at or above NREGS are ignored.
REQ-003 clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 i2c_sclk  input  1  I2C clock from the bus initiator; asynchronous to clk.
REQ-006 i2c_sdat_in  input  1  I2C data line as read from the pad; asynchronous to clk.
REQ-007 i2c_sdat_oe  output  1  1 = pull SDA low; 0 = release SDA (open-drain).
REQ-008 rd_addr  input  7  combinational register read address.
REQ-009 rd_data  output  9  contents of register rd_addr; 0 when rd_addr >= NREGS.
REQ-010 wr_strobe  output  1  one-cycle pulse on each committed register write.
REQ-011 wr_addr  output  7  register address of the last committed write; held between strobes.
REQ-012 wr_data  output  9  data of the last committed write; held between strobes.
REQ-013 busy  output  1  high from START detection until STOP detection or return to IDLE.
REQ-014 nack_count  output  8  saturating count of address phases NACKed because of a read request.

Function
REQ-015 SHALL pass sclk and sdat through two-flop synchronizers, then a third register for edge detection; bus events lag pins by 3 clk cycles.
REQ-016 START = sync SDA falls while sync SCL is high; STOP = sync SDA rises while sync SCL is high; both are valid in every state.
REQ-017 SHALL sample SDA on each sync SCL rising edge and shift data in MSB first.
REQ-018 States: IDLE, ADDR, ACK_A, BYTE1, ACK1, BYTE2, ACK2, WAIT_STOP.
REQ-019 IDLE->ADDR on START; any state->ADDR on repeated START, discarding any partial word.
REQ-020 ADDR: after 8 bits, match {DEV_ADDR,0} -> ACK_A; match {DEV_ADDR,1} -> increment nack_count and go to WAIT_STOP with no ACK; mismatch -> WAIT_STOP.
REQ-021 ACK: assert i2c_sdat_oe on the sync SCL falling edge that ends bit 8; deassert it on the next sync SCL falling edge; then advance (ACK_A->BYTE1, ACK1->BYTE2, ACK2->BYTE1).
REQ-022 Byte 1 = {reg_addr[6:0], data[8]}; byte 2 = data[7:0]; both bytes are always ACKed.
REQ-023 On completing the ACK2 release, commit the word: write the register if reg_addr < NREGS, and pulse wr_strobe in the same cycle for any reg_addr.
REQ-024 Multiple 16-bit words in one transaction SHALL each commit independently; a STOP between byte 1 and commit discards the partial word.
REQ-025 A write of any data to reg_addr 7'h0F SHALL load every register with its default value (same cycle as the commit) instead of storing the data.
REQ-026 STOP -> IDLE from any state, with i2c_sdat_oe released in the same cycle.
REQ-027 i2c_sdat_oe SHALL be 0 in every state except ACK_A, ACK1 and ACK2.
REQ-028 nack_count SHALL saturate at 8'hFF.

Reset
REQ-029 While reset_n = 0 at a clk edge: state = IDLE, i2c_sdat_oe = 0, busy = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, nack_count = 0, registers = defaults, and synchronizers are loaded with 1 (idle bus).
REQ-030 Reset mid-transaction SHALL abandon the transaction; the block then waits for a new START and ignores bits until then.

Structure
REQ-031 Package i2c_codec_pkg SHALL hold the state encoding, the reset-register address 7'h0F, and the default table: R0 9'h097, R1 9'h097, R2 9'h079, R3 9'h079, R4 9'h00A, R5 9'h008, R6 9'h09F, R7 9'h00A, R8..R15 9'h000.
REQ-032 One sub-module, i2c_sync_edge, SHALL implement the synchronizer and the rise/fall detection for a single line (instantiated twice).

Verification
REQ-033 Write 0x34, 0x08, 0x12 with SCL at clk/500 -> three ACKs; wr_strobe once; wr_addr = 4, wr_data = 9'h012; rd_addr = 4 reads 9'h012.
REQ-034 Address byte 0x35 (read) -> no ACK (oe never 1); nack_count = 1; registers unchanged.
REQ-035 Address byte 0x30 -> no ACK; wr_strobe never pulses; busy drops at STOP.
REQ-036 Write R4 = 9'h1FF, then write 0x1E, 0x00 -> R4 reads 9'h00A and R6 reads 9'h09F.
REQ-037 Two words in one transaction (R0 = 9'h100, R1 = 9'h055), then STOP after byte 1 of a third word -> exactly two strobes; third word discarded.
REQ-038 Assert reset_n = 0 during BYTE2 -> i2c_sdat_oe = 0 and state = IDLE next cycle; the following clean transaction commits correctly.
